hue_sequencer: RTL and testbench
================================

HUE_SEQUENCER -- requirements
Module: hue_sequencer

Interface
REQ-001 SHALL have parameter PWM_INTERVAL, default 1200, giving the PWM period in clk cycles (100 us at 12 MHz).
REQ-002 SHALL have parameter DUTY_STEP, default 12, giving the duty change per update; PWM_INTERVAL SHALL be an integer multiple of DUTY_STEP.
REQ-003 SHALL have parameter UPDATE_PERIODS, default 10, giving the number of PWM periods between duty updates.
REQ-004 SHALL have port clk, input, 1 bit: the single clock for all state.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port en, input, 1 bit: when 1, hue stepping is enabled.
REQ-007 SHALL have ports red, green and blue, each an output of 1 bit: active-high registered PWM outputs.
REQ-008 SHALL have port segment, output, 3 bits: the current hue segment, 0-5.
REQ-009 SHALL have port period_start, output, 1 bit: a one-cycle pulse marking the first cycle of each PWM period.

Function
REQ-010 SHALL hold a period counter cnt running 0..PWM_INTERVAL-1 and wrapping to 0 after PWM_INTERVAL-1, regardless of en.
REQ-011 SHALL drive period_start = 1 exactly when cnt == 0.
REQ-012 SHALL size the working duty registers dr, dg, db and the shadow registers sr, sg, sb at $clog2(PWM_INTERVAL+1) bits, so that the value PWM_INTERVAL is representable.
REQ-013 SHALL register the outputs so that red(t+1) = (cnt(t) < sr(t)), and likewise green from sg and blue from sb (one-cycle latency).
REQ-014 SHALL hold a channel output at 0 for its entire period when its duty is 0, and at 1 for its entire period when its duty is PWM_INTERVAL.
REQ-015 SHALL load the shadow registers only on the edge where cnt == PWM_INTERVAL-1, so that no duty change takes effect mid-period.
REQ-016 SHALL hold an update counter upd, 0..UPDATE_PERIODS-1, that advances on the cnt == PWM_INTERVAL-1 edge only while en == 1.
REQ-017 SHALL perform an update step on the edge where cnt == PWM_INTERVAL-1, upd == UPDATE_PERIODS-1 and en == 1; on that edge upd returns to 0.
REQ-018 SHALL load the shadow registers with the post-update duty values on an update edge.
REQ-019 SHALL implement the segment state machine, with the ramping channel moving by DUTY_STEP per update:
  - S0: R held at PWM_INTERVAL, G ramps up.
  - S1: G held at PWM_INTERVAL, R ramps down.
  - S2: G held, B ramps up.
  - S3: B held at PWM_INTERVAL, G ramps down.
  - S4: B held, R ramps up.
  - S5: R held at PWM_INTERVAL, B ramps down.
REQ-020 SHALL advance the segment (S5 wraps to S0) on the same update edge on which the ramping channel reaches its target (PWM_INTERVAL when ramping up, 0 when ramping down).
REQ-021 SHALL never let a duty value exceed PWM_INTERVAL or go below 0.
REQ-022 SHALL freeze the duty values, segment and upd while en == 0, while PWM output continues from the shadow registers.
REQ-023 SHALL resume from the frozen state when en returns to 1, with no skipped and no repeated step.
REQ-024 SHALL complete one full hue cycle in 6*PWM_INTERVAL/DUTY_STEP updates.

Reset
REQ-025 SHALL, while rst == 1 at a clk edge, set: cnt=0, upd=0, segment=0, dr=sr=PWM_INTERVAL, dg=sg=0, db=sb=0, red=green=blue=0, period_start=0.
REQ-026 SHALL give rst priority over en and over any in-progress update, so that reset mid-ramp fully restarts the sequence.
REQ-027 SHALL, on the first cycle after rst deasserts, have cnt == 0 and period_start == 1.

Verification (PWM_INTERVAL=8, DUTY_STEP=2, UPDATE_PERIODS=2, en=1 unless stated)
REQ-028 SHALL cover reset release: red is 1 for 8 of 8 cycles, green and blue are 0 for 8 of 8 cycles, and period_start pulses every 8 cycles.
REQ-029 SHALL cover the S0 ramp: updates land at cycles 15, 31, 47 and 63 after release; the green high count per period steps 0, 2, 4, 6, 8; segment becomes 1 at the cycle-63 edge.
REQ-030 SHALL cover the full cycle: after 24 updates (cycle 383) segment is 0 again, with dr=8, dg=0 and db=0.
REQ-031 SHALL cover pause: en is dropped for 40 cycles mid-S2; during the pause, segment and duties are unchanged and the PWM waveform repeats; after en rises, the next update occurs exactly 2 periods' worth of enabled wraps later.
REQ-032 SHALL cover reset mid-operation: rst is pulsed for 1 cycle during S4; afterward, the values of REQ-025 are restored and the sequence restarts as in REQ-029.
REQ-033 SHALL cover glitch-free duty changes: on every period, each output's high run is contiguous, starts at cnt==0, and its length equals the shadow value latched before that period.

Source files
------------

// File: rtl/hue_sequencer.sv
// RGB hue-wheel sequencer: three PWM channels whose duties walk the six
// colour-wheel segments, one DUTY_STEP per UPDATE_PERIODS PWM periods.
module hue_sequencer #(
  parameter int PWM_INTERVAL   = 1200,
  parameter int DUTY_STEP      = 12,
  parameter int UPDATE_PERIODS = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic       red,
  output logic       green,
  output logic       blue,
  output logic [2:0] segment,
  output logic       period_start
);
  localparam int CW = (PWM_INTERVAL > 1) ? $clog2(PWM_INTERVAL) : 1;
  localparam int UW = (UPDATE_PERIODS > 1) ? $clog2(UPDATE_PERIODS) : 1;
  localparam int DW = $clog2(PWM_INTERVAL + 1);

  localparam logic [DW-1:0] FULL = DW'(PWM_INTERVAL);
  localparam logic [DW-1:0] STEP = DW'(DUTY_STEP);
  localparam logic [CW-1:0] CMAX = CW'(PWM_INTERVAL - 1);
  localparam logic [UW-1:0] UMAX = UW'(UPDATE_PERIODS - 1);

  typedef enum logic [2:0] {S0, S1, S2, S3, S4, S5} seg_t;

  seg_t          state, nstate;
  logic [CW-1:0] cnt;
  logic [UW-1:0] upd;
  logic [DW-1:0] dr, dg, db, sr, sg, sb;
  logic [DW-1:0] nr, ng, nb;
  logic          wrap, step;

  assign wrap         = (cnt == CMAX);
  assign step         = wrap && en && (upd == UMAX);
  assign segment      = state;
  // Reset is folded in so the pulse appears on the first cycle after release.
  assign period_start = (cnt == '0) && !rst;

  // Next duty values for an update step; the compare-before-step clamps keep
  // every duty inside 0..PWM_INTERVAL even for non-multiple step sizes.
  always_comb begin
    nr     = dr;
    ng     = dg;
    nb     = db;
    nstate = state;
    case (state)
      S0: if (dg >= FULL - STEP) begin ng = FULL; nstate = S1; end
          else ng = dg + STEP;
      S1: if (dr <= STEP) begin nr = '0; nstate = S2; end
          else nr = dr - STEP;
      S2: if (db >= FULL - STEP) begin nb = FULL; nstate = S3; end
          else nb = db + STEP;
      S3: if (dg <= STEP) begin ng = '0; nstate = S4; end
          else ng = dg - STEP;
      S4: if (dr >= FULL - STEP) begin nr = FULL; nstate = S5; end
          else nr = dr + STEP;
      S5: if (db <= STEP) begin nb = '0; nstate = S0; end
          else nb = db - STEP;
      default: nstate = S0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      upd   <= '0;
      state <= S0;
      dr    <= FULL;
      dg    <= '0;
      db    <= '0;
      sr    <= FULL;
      sg    <= '0;
      sb    <= '0;
      red   <= 1'b0;
      green <= 1'b0;
      blue  <= 1'b0;
    end else begin
      red   <= DW'(cnt) < sr;
      green <= DW'(cnt) < sg;
      blue  <= DW'(cnt) < sb;
      cnt   <= wrap ? '0 : cnt + 1'b1;
      // Duties and shadows only move at the period boundary.
      if (wrap) begin
        if (en) upd <= (upd == UMAX) ? '0 : upd + 1'b1;
        if (step) begin
          dr    <= nr;
          dg    <= ng;
          db    <= nb;
          state <= nstate;
          sr    <= nr;
          sg    <= ng;
          sb    <= nb;
        end else begin
          sr <= dr;
          sg <= dg;
          sb <= db;
        end
      end
    end
  end
endmodule

// File: tb/tb_hue_sequencer.sv
// Bench for hue_sequencer: directed reset/ramp/pause/reset scenarios, then random
// en/rst traffic, all checked cycle by cycle against a hue-index reference model.
module tb_hue_sequencer;
  localparam int PI  = 8;
  localparam int ST  = 2;
  localparam int UP  = 2;
  localparam int N   = PI / ST;
  localparam int HUE = 6 * N;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b1;
  logic       red, green, blue, period_start;
  logic [2:0] segment;

  hue_sequencer #(.PWM_INTERVAL(PI), .DUTY_STEP(ST), .UPDATE_PERIODS(UP)) dut (
    .clk(clk), .rst(rst), .en(en), .red(red), .green(green), .blue(blue),
    .segment(segment), .period_start(period_start)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Model: position on the hue wheel is just the number of completed updates.
  int m_cnt, m_upd, m_k;
  int m_sr, m_sg, m_sb;
  int m_red, m_green, m_blue;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  function automatic void duty(input int k, output int r, output int g, output int b);
    int s, v;
    s = (k % HUE) / N;
    v = (k % N) * ST;
    case (s)
      0: begin r = PI;     g = v;      b = 0;      end
      1: begin r = PI - v; g = PI;     b = 0;      end
      2: begin r = 0;      g = PI;     b = v;      end
      3: begin r = 0;      g = PI - v; b = PI;     end
      4: begin r = v;      g = 0;      b = PI;     end
      default: begin r = PI; g = 0;    b = PI - v; end
    endcase
  endfunction

  task automatic step();
    int er, eg, eb;
    @(posedge clk);
    if (rst) begin
      m_cnt = 0; m_upd = 0; m_k = 0;
      m_sr = PI; m_sg = 0; m_sb = 0;
      m_red = 0; m_green = 0; m_blue = 0;
    end else begin
      m_red   = int'(m_cnt < m_sr);
      m_green = int'(m_cnt < m_sg);
      m_blue  = int'(m_cnt < m_sb);
      if (m_cnt == PI - 1) begin
        m_cnt = 0;
        if (en) begin
          if (m_upd == UP - 1) begin m_upd = 0; m_k = (m_k + 1) % HUE; end
          else m_upd++;
        end
        duty(m_k, m_sr, m_sg, m_sb);
      end else m_cnt++;
    end
    #1;
    duty(m_k, er, eg, eb);
    chk("red", int'(red), m_red);
    chk("green", int'(green), m_green);
    chk("blue", int'(blue), m_blue);
    chk("segment", int'(segment), m_k / N);
    chk("period_start", int'(period_start), int'(m_cnt == 0 && !rst));
    chk("dr", int'(dut.dr), er);
    chk("dg", int'(dut.dg), eg);
    chk("db", int'(dut.db), eb);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int highs;
    rst = 1'b1; en = 1'b1;
    run(3);
    chk("rst_seg", int'(segment), 0);
    chk("rst_red", int'(red), 0);
    chk("rst_ps", int'(period_start), 0);
    chk("rst_dr", int'(dut.dr), PI);

    // Release: cycle 0 is the one right after deassertion.
    rst = 1'b0;
    #1;
    chk("rel_ps", int'(period_start), 1);
    chk("rel_cnt", int'(dut.cnt), 0);
    highs = 0;
    for (int i = 0; i < PI; i++) begin step(); highs += int'(red); end
    chk("rel_red_high", highs, PI);
    run(63 - PI);
    chk("s0_seg_before", int'(segment), 0);
    chk("s0_dg_before", int'(dut.dg), 6);
    run(1);
    chk("s0_seg_after", int'(segment), 1);
    chk("s0_dg_after", int'(dut.dg), PI);
    run(384 - 64);
    chk("full_seg", int'(segment), 0);
    chk("full_dr", int'(dut.dr), PI);
    chk("full_dg", int'(dut.dg), 0);
    chk("full_db", int'(dut.db), 0);

    // Pause mid-S2.
    for (int i = 0; i < 400 && !(segment == 3'd2 && dut.db == 2); i++) step();
    chk("reach_s2", int'(dut.db), 2);
    run(5);
    en = 1'b0;
    run(40);
    chk("pause_seg", int'(segment), 2);
    chk("pause_db", int'(dut.db), 2);
    en = 1'b1;

    // Reset pulse in S4, then the S0 ramp must replay.
    for (int i = 0; i < 800 && segment != 3'd4; i++) step();
    chk("reach_s4", int'(segment), 4);
    run(20);
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    #1;
    chk("rst2_ps", int'(period_start), 1);
    chk("rst2_dr", int'(dut.dr), PI);
    chk("rst2_db", int'(dut.db), 0);
    run(64);
    chk("rst2_seg", int'(segment), 1);

    // Random en / occasional reset.
    for (int i = 0; i < 3000; i++) begin
      en  = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 299) == 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
